// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed seven-segment driver for the 16-bit ALU result bus.
// Captures a word on Load, then scans the digits with dead time, leading-zero blanking and a status decimal point.
module hex_display_scanner #(
    parameter int REFRESH_COUNT = 50000,
    parameter int DEAD_CYCLES   = 2,
    parameter bit BLANK_LEADING = 1'b1,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Value,
    input  logic        Flag,
    input  logic        Load,
    input  logic        Enable,
    output logic [3:0]  Anodes,
    output logic [6:0]  Segments,
    output logic        DecimalPoint,
    output logic        DigitTick
);

    localparam int CountWidth = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(REFRESH_COUNT - 1);
    localparam logic [CountWidth-1:0] DeadLimit = CountWidth'(DEAD_CYCLES);

    // XOR masks that turn the active-high internal form into board polarity.
    localparam logic [3:0] AnodeMask   = {4{ACTIVE_LOW}};
    localparam logic [6:0] SegmentMask = {7{ACTIVE_LOW}};
    localparam logic       PointMask   = ACTIVE_LOW;

    logic [15:0]           heldValue;
    logic                  heldFlag;
    logic [CountWidth-1:0] count;
    logic [1:0]            digitIdx;

    logic [3:0] nibble;
    logic [3:0] zeroFrom;
    logic       digitBlanked;
    logic       inDead;
    logic [3:0] nextAnodes;
    logic [6:0] nextSegments;
    logic       nextPoint;

    function automatic logic [6:0] hexToSegments(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

    // zeroFrom[i]: nibbles i..3 are all zero; digit 0 is never blanked.
    assign zeroFrom[3] = (heldValue[15:12] == 4'h0);
    assign zeroFrom[2] = zeroFrom[3] && (heldValue[11:8] == 4'h0);
    assign zeroFrom[1] = zeroFrom[2] && (heldValue[7:4] == 4'h0);
    assign zeroFrom[0] = 1'b0;

    assign digitBlanked = BLANK_LEADING && zeroFrom[digitIdx];
    assign inDead       = (count < DeadLimit);

    always_comb begin
        case (digitIdx)
            2'd0:    nibble = heldValue[3:0];
            2'd1:    nibble = heldValue[7:4];
            2'd2:    nibble = heldValue[11:8];
            default: nibble = heldValue[15:12];
        endcase
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves a latch behind.
        nextAnodes   = 4'b0000;
        nextSegments = 7'b0000000;
        nextPoint    = 1'b0;
        if (Enable && !inDead && !digitBlanked) begin
            nextAnodes   = 4'b0001 << digitIdx;
            nextSegments = hexToSegments(nibble);
            nextPoint    = heldFlag && (digitIdx == 2'd0);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            heldValue    <= 16'h0000;
            heldFlag     <= 1'b0;
            count        <= '0;
            digitIdx     <= 2'd0;
            DigitTick    <= 1'b0;
            Anodes       <= AnodeMask;
            Segments     <= SegmentMask;
            DecimalPoint <= PointMask;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge state.
            if (Load) begin
                heldValue <= Value;
                heldFlag  <= Flag;
            end
            DigitTick <= 1'b0;
            if (Enable) begin
                if (count == LastCount) begin
                    count     <= '0;
                    digitIdx  <= digitIdx + 2'd1;
                    DigitTick <= 1'b1;
                end else begin
                    count <= count + CountWidth'(1);
                end
            end
            Anodes       <= nextAnodes ^ AnodeMask;
            Segments     <= nextSegments ^ SegmentMask;
            DecimalPoint <= nextPoint ^ PointMask;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed plus randomized bench for hex_display_scanner: two instances (active-high with blanking,
// active-low without blanking) checked every cycle against a scan-position reference model.
module tb_hex_display_scanner;

    localparam int RC   = 4;
    localparam int DEAD = 1;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Value = 16'h0000;
    logic        Flag = 1'b0;
    logic        Load = 1'b0;
    logic        Enable = 1'b0;

    logic [3:0] anodesHi, anodesLo;
    logic [6:0] segmentsHi, segmentsLo;
    logic       pointHi, pointLo;
    logic       tickHi, tickLo;

    hex_display_scanner #(.REFRESH_COUNT(RC), .DEAD_CYCLES(DEAD), .BLANK_LEADING(1'b1), .ACTIVE_LOW(1'b0)) dutHi (
        .Clock(Clock), .Reset(Reset), .Value(Value), .Flag(Flag), .Load(Load), .Enable(Enable),
        .Anodes(anodesHi), .Segments(segmentsHi), .DecimalPoint(pointHi), .DigitTick(tickHi)
    );

    hex_display_scanner #(.REFRESH_COUNT(RC), .DEAD_CYCLES(DEAD), .BLANK_LEADING(1'b0), .ACTIVE_LOW(1'b1)) dutLo (
        .Clock(Clock), .Reset(Reset), .Value(Value), .Flag(Flag), .Load(Load), .Enable(Enable),
        .Anodes(anodesLo), .Segments(segmentsLo), .DecimalPoint(pointLo), .DigitTick(tickLo)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        logic       blanked;
    } expect_t;

    logic [6:0] segTable [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference state: enabled cycles since reset, modulo one full four-digit frame.
    int          scanPos = 0;
    logic [15:0] mHeld = 16'h0000;
    logic        mFlag = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic expect_t predict(input bit blankEn, input bit en);
        expect_t e;
        int cnt, dig, upper;
        e = '0;
        cnt = scanPos % RC;
        dig = (scanPos / RC) % 4;
        upper = int'(mHeld) >> (4 * dig);
        e.tick = en && (cnt == RC - 1);
        e.blanked = blankEn && (dig > 0) && (upper == 0);
        if (en && cnt >= DEAD && !e.blanked) begin
            e.an  = 4'(1 << dig);
            e.seg = segTable[upper % 16];
            e.dp  = mFlag && (dig == 0);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t: observed %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic en, input logic [15:0] val, input logic flg);
        expect_t eHi, eLo;
        Reset = rst; Load = ld; Enable = en; Value = val; Flag = flg;
        @(posedge Clock);
        if (rst) begin
            eHi = '0;
            eLo = '0;
            mHeld = 16'h0000;
            mFlag = 1'b0;
            scanPos = 0;
        end else begin
            eHi = predict(1'b1, en);
            eLo = predict(1'b0, en);
            if (ld) begin
                mHeld = val;
                mFlag = flg;
            end
            if (en) scanPos = (scanPos + 1) % (4 * RC);
        end
        #1;
        check("hi_anodes", 16'(anodesHi), 16'(eHi.an));
        if (!eHi.blanked) check("hi_segments", 16'(segmentsHi), 16'(eHi.seg));
        check("hi_point", 16'(pointHi), 16'(eHi.dp));
        check("hi_tick", 16'(tickHi), 16'(eHi.tick));
        check("lo_anodes", 16'(anodesLo), 16'(eLo.an ^ 4'hF));
        check("lo_segments", 16'(segmentsLo), 16'(eLo.seg ^ 7'h7F));
        check("lo_point", 16'(pointLo), 16'(eLo.dp ^ 1'b1));
        check("lo_tick", 16'(tickLo), 16'(eLo.tick));
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 16'($urandom), 1'($urandom));
    endtask

    task automatic runTo(input int target);
        for (int i = 0; i < 4 * RC && scanPos != target; i++) step(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0);
    endtask

    initial begin
        @(negedge Clock);
        // Reset dominates a simultaneous Load.
        step(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Plain four-digit scan, Value wiggling without Load.
        step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
        idle(20);

        // Leading-zero blanking cases.
        step(1'b0, 1'b1, 1'b1, 16'h0005, 1'b0);
        idle(18);
        step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
        idle(18);
        step(1'b0, 1'b1, 1'b1, 16'h0300, 1'b0);
        idle(18);

        // Held data ignores Value changes without Load.
        step(1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);

        // Freeze on digit 2 count 2; a Load while disabled is still honoured.
        runTo(2 * RC + 2);
        for (int i = 0; i < 10; i++) step(1'b0, (i == 4), 1'b0, 16'h4321, 1'b0);
        idle(10);

        // Reset mid-scan on digit 3, then restart showing "0".
        runTo(3 * RC + 2);
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
        idle(10);

        // Decimal point from the captured flag.
        step(1'b0, 1'b1, 1'b1, 16'h0001, 1'b1);
        idle(18);

        // Load on the wrap edge and inside an active window.
        runTo(RC - 1);
        step(1'b0, 1'b1, 1'b1, 16'h9876, 1'b0);
        runTo(RC + 2);
        step(1'b0, 1'b1, 1'b1, 16'hE0F0, 1'b1);
        idle(8);

        // Randomized traffic: sparse loads, occasional disable and reset.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] v;
            v = 16'($urandom) >> (4 * $urandom_range(0, 3));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) != 0), v, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
